core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
Multi-cycle sequencer for the RV32I core. It steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and runs req/ack handshakes to instruction and data memory. It gates the decoder's register and memory write enables so each one fires in exactly one cycle, and it counts retired instructions. Illegal instructions and memory timeouts send it to a sticky TRAP state.

Parameters:
TIMEOUT_CYCLES, 16, consecutive un-acked request cycles that trigger a trap (must be >= 2)
INSTRET_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  instruction fetch request
imem_ack  input  1  fetch data valid this cycle
ir_load  output  1  capture the instruction register this cycle
dec_reg_write  input  1  decoder register_write_enable
dec_mem_write  input  4  decoder memory_write_enable byte mask
dec_mem_read  input  1  decoder flags a load
dec_illegal  input  1  decoder flags an unsupported opcode/funct
dmem_req  output  1  data memory request
dmem_we  output  4  gated byte write mask
dmem_ack  input  1  data access complete
load_capture  output  1  latch load data this cycle
reg_write_enable  output  1  gated register-file write
pc_write_enable  output  1  PC update strobe
state  output  3  current state encoding
halted  output  1  sticky trap indicator
trap_cause  output  2  00 none, 01 illegal, 10 fetch timeout, 11 data timeout
instret  output  INSTRET_WIDTH  retired instruction count

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=FETCH(0), halted=0, trap_cause=00, instret=0, wait counter=0.
  - All strobes are 0 while rst=1. imem_req goes high in the first cycle after rst deasserts.
  - rst overrides every other event, including ack in the same cycle.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5. Codes 6-7 go to TRAP with cause 01.
- Outputs are combinational from state plus the current ack/decoder inputs.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_load=1 in the same cycle, next state DECODE.
- DECODE:
  - One cycle, to let the decoder settle.
  - dec_illegal=1 -> TRAP with cause 01; otherwise EXECUTE.
- EXECUTE:
  - One cycle.
  - If dec_mem_read=1 or dec_mem_write!=0 -> MEMORY; otherwise WRITEBACK.
- MEMORY:
  - dmem_req=1; dmem_we=dec_mem_write (0 outside MEMORY).
  - On dmem_ack: load_capture=dec_mem_read, next state WRITEBACK.
- WRITEBACK:
  - One cycle: reg_write_enable=dec_reg_write, pc_write_enable=1, instret increments, next state FETCH.
  - Minimum latency: 4 cycles per ALU instruction (ack on the first request cycle), 5 per load/store.
- Timeout:
  - The wait counter clears on entering FETCH or MEMORY and increments each cycle the request is held without ack.
  - If the count reaches TIMEOUT_CYCLES-1 and ack is still 0 -> TRAP with cause 10 (FETCH) or 11 (MEMORY).
  - An ack arriving in the limit cycle wins; no trap.
- TRAP:
  - All requests and strobes are 0; halted=1; trap_cause holds.
  - Stays in TRAP until rst. Acks arriving in TRAP are ignored.
- instret wraps from all-ones to 0 without a flag.
- Write gating: reg_write_enable, pc_write_enable and dmem_we are never nonzero outside WRITEBACK and MEMORY respectively. Each fires exactly once per retired instruction.
- No pipelining: the next imem_req is issued only after WRITEBACK.

Decomposition:
- Shared package holds:
  - the state encoding constants (SEQ_FETCH..SEQ_TRAP);
  - the trap cause constants (TRAP_NONE, TRAP_ILLEGAL, TRAP_IFETCH_TO, TRAP_DMEM_TO);
  - the default TIMEOUT_CYCLES.
- One sub-module, seq_wait_timer: inputs clear and count, output expired, width $clog2(TIMEOUT_CYCLES). Instantiated once and shared by FETCH and MEMORY.

Test Plan:
- ALU instruction (dec_reg_write=1, no memory), imem_ack on the first FETCH cycle -> states 0,1,2,4,0; reg_write_enable=1 and pc_write_enable=1 only in cycle 4; instret 0->1.
- Store with dec_mem_write=4'b0011, dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles; dmem_we=0011 in MEMORY only; reg_write_enable=0 in WRITEBACK; instret +1.
- Load with dmem_ack after 1 cycle -> load_capture=1 exactly in the ack cycle; reg_write_enable=1 in the following cycle.
- dec_illegal=1 in DECODE -> state=5, halted=1, trap_cause=01; stays there for 20 cycles with random acks; rst -> FETCH, instret=0.
- imem_ack never asserted, TIMEOUT_CYCLES=16 -> TRAP (cause 10) after 16 FETCH cycles. Separate run with ack in the 16th FETCH cycle -> no trap, DECODE follows.
- rst asserted mid-MEMORY together with dmem_ack -> state=0 next cycle, dmem_req=0, no writeback; instret preset to all-ones and one retire -> instret wraps to 0.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: state codes, trap causes
// and the default request timeout.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_FETCH     = 3'd0,
    SEQ_DECODE    = 3'd1,
    SEQ_EXECUTE   = 3'd2,
    SEQ_MEMORY    = 3'd3,
    SEQ_WRITEBACK = 3'd4,
    SEQ_TRAP      = 3'd5
  } seq_state_t;

  localparam logic [1:0] TRAP_NONE      = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL   = 2'b01;
  localparam logic [1:0] TRAP_IFETCH_TO = 2'b10;
  localparam logic [1:0] TRAP_DMEM_TO   = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/seq_wait_timer.sv
// Counts consecutive un-acked request cycles; expired flags the last allowed cycle.
// Shared by the FETCH and MEMORY waits, cleared on entry to either.
module seq_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (count) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with imem/dmem req/ack,
// one-shot write gating, retired-instruction counter and a sticky TRAP state.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int INSTRET_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  input  logic                     imem_ack,
  output logic                     ir_load,
  input  logic                     dec_reg_write,
  input  logic [3:0]               dec_mem_write,
  input  logic                     dec_mem_read,
  input  logic                     dec_illegal,
  output logic                     dmem_req,
  output logic [3:0]               dmem_we,
  input  logic                     dmem_ack,
  output logic                     load_capture,
  output logic                     reg_write_enable,
  output logic                     pc_write_enable,
  output logic [2:0]               state,
  output logic                     halted,
  output logic [1:0]               trap_cause,
  output logic [INSTRET_WIDTH-1:0] instret
);

  seq_state_t               r_state;
  logic [1:0]               r_trap_cause;
  logic [INSTRET_WIDTH-1:0] r_instret;

  seq_state_t w_next;
  logic       w_trap;
  logic [1:0] w_cause;
  logic       w_imem_req, w_ir_load, w_dmem_req, w_load_cap, w_rwe, w_pwe;
  logic [3:0] w_dmem_we;
  logic       w_count, w_clear, w_expired;

  // Clear only on a real transition into a waiting state, so the count spans the whole wait.
  assign w_clear = (w_next != r_state) && ((w_next == SEQ_FETCH) || (w_next == SEQ_MEMORY));

  seq_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .count   (w_count),
    .expired (w_expired)
  );

  always_comb begin
    w_next     = r_state;
    w_trap     = 1'b0;
    w_cause    = TRAP_NONE;
    w_imem_req = 1'b0;
    w_ir_load  = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 4'b0000;
    w_load_cap = 1'b0;
    w_rwe      = 1'b0;
    w_pwe      = 1'b0;
    w_count    = 1'b0;
    case (r_state)
      SEQ_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ack) begin
          w_ir_load = 1'b1;
          w_next    = SEQ_DECODE;
        end else if (w_expired) begin
          w_next  = SEQ_TRAP;
          w_trap  = 1'b1;
          w_cause = TRAP_IFETCH_TO;
        end else begin
          w_count = 1'b1;
        end
      end
      SEQ_DECODE: begin
        if (dec_illegal) begin
          w_next  = SEQ_TRAP;
          w_trap  = 1'b1;
          w_cause = TRAP_ILLEGAL;
        end else begin
          w_next = SEQ_EXECUTE;
        end
      end
      SEQ_EXECUTE: begin
        w_next = (dec_mem_read || (dec_mem_write != 4'b0000)) ? SEQ_MEMORY : SEQ_WRITEBACK;
      end
      SEQ_MEMORY: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = dec_mem_write;
        if (dmem_ack) begin
          w_load_cap = dec_mem_read;
          w_next     = SEQ_WRITEBACK;
        end else if (w_expired) begin
          w_next  = SEQ_TRAP;
          w_trap  = 1'b1;
          w_cause = TRAP_DMEM_TO;
        end else begin
          w_count = 1'b1;
        end
      end
      SEQ_WRITEBACK: begin
        w_rwe  = dec_reg_write;
        w_pwe  = 1'b1;
        w_next = SEQ_FETCH;
      end
      SEQ_TRAP: begin
        w_next = SEQ_TRAP;
      end
      default: begin
        w_next  = SEQ_TRAP;
        w_trap  = 1'b1;
        w_cause = TRAP_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SEQ_FETCH;
      r_trap_cause <= TRAP_NONE;
      r_instret    <= '0;
    end else begin
      r_state <= w_next;
      if (w_trap) begin
        r_trap_cause <= w_cause;
      end
      if (r_state == SEQ_WRITEBACK) begin
        r_instret <= r_instret + 1'b1;
      end
    end
  end

  // Strobes are forced low for the whole reset cycle regardless of state.
  assign imem_req         = w_imem_req & ~rst;
  assign ir_load          = w_ir_load  & ~rst;
  assign dmem_req         = w_dmem_req & ~rst;
  assign dmem_we          = w_dmem_we  & {4{~rst}};
  assign load_capture     = w_load_cap & ~rst;
  assign reg_write_enable = w_rwe      & ~rst;
  assign pc_write_enable  = w_pwe      & ~rst;
  assign state            = r_state;
  assign halted           = (r_state == SEQ_TRAP);
  assign trap_cause       = r_trap_cause;
  assign instret          = r_instret;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed-vector bench for core_sequencer; a second 2-bit-instret instance shares
// all inputs so the counter wrap can be observed in a few instructions.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        dec_reg_write = 1'b0, dec_mem_read = 1'b0, dec_illegal = 1'b0;
  logic [3:0]  dec_mem_write = 4'b0000;

  logic        imem_req, ir_load, dmem_req, load_capture, reg_write_enable, pc_write_enable, halted;
  logic [3:0]  dmem_we;
  logic [2:0]  state;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  logic        w2_imem_req, w2_ir_load, w2_dmem_req, w2_load_capture, w2_rwe, w2_pwe, w2_halted;
  logic [3:0]  w2_dmem_we;
  logic [2:0]  w2_state;
  logic [1:0]  w2_trap_cause;
  logic [1:0]  w2_instret;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT_CYCLES(16), .INSTRET_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write), .dec_mem_read(dec_mem_read),
    .dec_illegal(dec_illegal), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .load_capture(load_capture), .reg_write_enable(reg_write_enable),
    .pc_write_enable(pc_write_enable), .state(state), .halted(halted),
    .trap_cause(trap_cause), .instret(instret)
  );

  core_sequencer #(.TIMEOUT_CYCLES(16), .INSTRET_WIDTH(2)) dut_w2 (
    .clk(clk), .rst(rst), .imem_req(w2_imem_req), .imem_ack(imem_ack), .ir_load(w2_ir_load),
    .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write), .dec_mem_read(dec_mem_read),
    .dec_illegal(dec_illegal), .dmem_req(w2_dmem_req), .dmem_we(w2_dmem_we), .dmem_ack(dmem_ack),
    .load_capture(w2_load_capture), .reg_write_enable(w2_rwe),
    .pc_write_enable(w2_pwe), .state(w2_state), .halted(w2_halted),
    .trap_cause(w2_trap_cause), .instret(w2_instret)
  );

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic cyc(input logic r, input logic ia, input logic da);
    @(posedge clk);
    #2;
    rst = r; imem_ack = ia; dmem_ack = da;
    #1;
  endtask

  task automatic set_dec(input logic rw, input logic [3:0] mw, input logic mr, input logic ill);
    dec_reg_write = rw; dec_mem_write = mw; dec_mem_read = mr; dec_illegal = ill;
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b1, 1'b1);
    n_vec++; if ({imem_req, ir_load, dmem_req, dmem_we, load_capture, reg_write_enable, pc_write_enable} !== 10'b0) begin
      n_err++; $display("FAIL rst_strobes got %b want 0", {imem_req, ir_load, dmem_req, dmem_we, load_capture, reg_write_enable, pc_write_enable}); end
    cyc(1'b1, 1'b1, 1'b1);
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", state); end
    n_vec++; if ({halted, trap_cause} !== 3'b000) begin n_err++; $display("FAIL rst_trap got %b want 000", {halted, trap_cause}); end
    n_vec++; if (instret !== 32'd0) begin n_err++; $display("FAIL rst_instret got %0d want 0", instret); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rst_first_req got %b want 1", imem_req); end
  endtask

  task automatic test_alu;
    set_dec(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    n_vec++; if ({state, imem_req, ir_load, reg_write_enable} !== {3'd0, 3'b110}) begin
      n_err++; $display("FAIL alu_fetch got %b want 000110", {state, imem_req, ir_load, reg_write_enable}); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, imem_req, ir_load} !== {3'd1, 2'b00}) begin
      n_err++; $display("FAIL alu_decode got %b want 00100", {state, imem_req, ir_load}); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, reg_write_enable, pc_write_enable} !== {3'd2, 2'b00}) begin
      n_err++; $display("FAIL alu_execute got %b want 01000", {state, reg_write_enable, pc_write_enable}); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, reg_write_enable, pc_write_enable, dmem_req} !== {3'd4, 3'b110}) begin
      n_err++; $display("FAIL alu_wb got %b want 100110", {state, reg_write_enable, pc_write_enable, dmem_req}); end
    n_vec++; if (instret !== 32'd0) begin n_err++; $display("FAIL alu_instret_wb got %0d want 0", instret); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, reg_write_enable, pc_write_enable} !== {3'd0, 2'b00}) begin
      n_err++; $display("FAIL alu_back_fetch got %b want 00000", {state, reg_write_enable, pc_write_enable}); end
    n_vec++; if (instret !== 32'd1) begin n_err++; $display("FAIL alu_instret got %0d want 1", instret); end
  endtask

  task automatic test_store;
    set_dec(1'b0, 4'b0011, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, dmem_req, dmem_we} !== {3'd2, 5'b00000}) begin
      n_err++; $display("FAIL st_execute got %b want 01000000", {state, dmem_req, dmem_we}); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, (i == 3));
      n_vec++; if ({state, dmem_req, dmem_we, load_capture} !== {3'd3, 1'b1, 4'b0011, 1'b0}) begin
        n_err++; $display("FAIL st_mem%0d got %b want 011100110", i, {state, dmem_req, dmem_we, load_capture}); end
    end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, dmem_req, dmem_we, reg_write_enable, pc_write_enable} !== {3'd4, 5'b00000, 2'b01}) begin
      n_err++; $display("FAIL st_wb got %b want 1000000001", {state, dmem_req, dmem_we, reg_write_enable, pc_write_enable}); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, instret} !== {3'd0, 32'd2}) begin
      n_err++; $display("FAIL st_done state %0d instret %0d want 0 2", state, instret); end
  endtask

  task automatic test_load;
    set_dec(1'b1, 4'b0000, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, dmem_req, load_capture} !== {3'd3, 2'b10}) begin
      n_err++; $display("FAIL ld_mem0 got %b want 01110", {state, dmem_req, load_capture}); end
    cyc(1'b0, 1'b0, 1'b1);
    n_vec++; if ({state, load_capture, dmem_we, reg_write_enable} !== {3'd3, 1'b1, 4'b0000, 1'b0}) begin
      n_err++; $display("FAIL ld_ack got %b want 011100000", {state, load_capture, dmem_we, reg_write_enable}); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, load_capture, reg_write_enable} !== {3'd4, 2'b01}) begin
      n_err++; $display("FAIL ld_wb got %b want 10001", {state, load_capture, reg_write_enable}); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if (instret !== 32'd3) begin n_err++; $display("FAIL ld_instret got %0d want 3", instret); end
  endtask

  task automatic test_illegal;
    set_dec(1'b1, 4'b0000, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL ill_decode got %0d want 1", state); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, halted, trap_cause} !== {3'd5, 1'b1, 2'b01}) begin
      n_err++; $display("FAIL ill_trap got %b want 101101", {state, halted, trap_cause}); end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_vec++; if ({state, halted, trap_cause, imem_req, ir_load, dmem_req, dmem_we, load_capture, reg_write_enable, pc_write_enable, instret}
                   !== {3'd5, 1'b1, 2'b01, 10'b0, 32'd3}) begin
        n_err++; $display("FAIL ill_hold%0d state %0d halted %b cause %b instret %0d", i, state, halted, trap_cause, instret); end
    end
    set_dec(1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_fetch_timeout;
    set_dec(1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, imem_req} !== {3'd0, 1'b1}) begin
      n_err++; $display("FAIL ito_cycle16 got %b want 0001", {state, imem_req}); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, halted, trap_cause, imem_req} !== {3'd5, 1'b1, 2'b10, 1'b0}) begin
      n_err++; $display("FAIL ito_trap got %b want 1011100", {state, halted, trap_cause, imem_req}); end
  endtask

  task automatic test_fetch_limit_ack;
    set_dec(1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    n_vec++; if ({state, ir_load} !== {3'd0, 1'b1}) begin
      n_err++; $display("FAIL ilim_ack got %b want 0001", {state, ir_load}); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, halted} !== {3'd1, 1'b0}) begin
      n_err++; $display("FAIL ilim_decode got %b want 0010", {state, halted}); end
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, instret} !== {3'd0, 32'd1}) begin
      n_err++; $display("FAIL ilim_retire state %0d instret %0d want 0 1", state, instret); end
  endtask

  task automatic test_dmem_timeout;
    set_dec(1'b1, 4'b0000, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, dmem_req} !== {3'd3, 1'b1}) begin
      n_err++; $display("FAIL dto_cycle16 got %b want 0111", {state, dmem_req}); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, halted, trap_cause, dmem_req, reg_write_enable} !== {3'd5, 1'b1, 2'b11, 2'b00}) begin
      n_err++; $display("FAIL dto_trap got %b want 10111100", {state, halted, trap_cause, dmem_req, reg_write_enable}); end
  endtask

  task automatic test_rst_mid_memory;
    set_dec(1'b1, 4'b0001, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    n_vec++; if ({state, dmem_req, dmem_we, load_capture} !== {3'd3, 6'b0}) begin
      n_err++; $display("FAIL rmem_gated got %b want 011000000", {state, dmem_req, dmem_we, load_capture}); end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if ({state, dmem_req, reg_write_enable, pc_write_enable, instret} !== {3'd0, 3'b000, 32'd0}) begin
      n_err++; $display("FAIL rmem_after state %0d rwe %b pwe %b instret %0d want 0 0 0 0", state, reg_write_enable, pc_write_enable, instret); end
  endtask

  task automatic test_back_to_back_wrap;
    set_dec(1'b1, 4'b0000, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      n_vec++; if ({state, pc_write_enable, w2_instret} !== {3'd4, 1'b1, 2'(n)}) begin
        n_err++; $display("FAIL b2b_wb%0d state %0d pwe %b w2_instret %0d want 4 1 %0d", n, state, pc_write_enable, w2_instret, n); end
    end
    cyc(1'b0, 1'b0, 1'b0);
    n_vec++; if (instret !== 32'd4) begin n_err++; $display("FAIL b2b_instret got %0d want 4", instret); end
    n_vec++; if (w2_instret !== 2'd0) begin n_err++; $display("FAIL wrap_instret got %0d want 0", w2_instret); end
    n_vec++; if ({w2_state, w2_imem_req, w2_ir_load, w2_dmem_req, w2_dmem_we, w2_load_capture, w2_rwe, w2_pwe, w2_halted, w2_trap_cause}
                 !== {3'd0, 1'b1, 12'b0}) begin
      n_err++; $display("FAIL wrap_fetch got %b want 0001000000000000", {w2_state, w2_imem_req, w2_ir_load, w2_dmem_req, w2_dmem_we, w2_load_capture, w2_rwe, w2_pwe, w2_halted, w2_trap_cause}); end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_store;
    test_load;
    test_illegal;
    test_reset;
    test_fetch_timeout;
    test_reset;
    test_fetch_limit_ack;
    test_dmem_timeout;
    test_reset;
    test_rst_mid_memory;
    test_back_to_back_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
